// File: rtl/input_byte_receiver.sv
// rtl/input_byte_receiver.sv - four-phase pin handshake capturing bytes into a small FIFO toward the cipher core
// Optional macro INPUT_SYNC_EN adds a two-flop synchronizer on input_byte_valid.
module input_byte_receiver #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] data_in,
   input  logic       input_byte_valid,
   output logic       input_acknowledge,
   input  logic       flush,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {REARM, IDLE, ACK} state_t;

   state_t          state_q;
   logic            ack_q;
   logic            valid_s;
   logic            rearm_ok;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [AW:0]     count_q, count_d;
   logic            full, push, pop;

`ifdef INPUT_SYNC_EN
   logic       sync1_q, sync2_q;
   logic [1:0] settle_q;

   // REARM may only trust valid_s once the chain holds real pin samples, not its reset zeros.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         settle_q <= 2'b00;
      end else begin
         sync1_q  <= input_byte_valid;
         sync2_q  <= sync1_q;
         settle_q <= {settle_q[0], 1'b1};
      end
   end

   assign valid_s  = sync2_q;
   assign rearm_ok = settle_q[1];
`else
   assign valid_s  = input_byte_valid;
   assign rearm_ok = 1'b1;
`endif

   assign full       = (count_q == CNT_FULL);
   assign byte_valid = (count_q != '0);
   assign byte_out   = mem_q[rptr_q];
   assign input_acknowledge = ack_q;

   // Push decision uses the pre-pop full flag, so a same-edge pop never frees a slot early.
   assign push = (state_q == IDLE) && valid_s && !full;
   assign pop  = byte_valid && byte_ready;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= REARM;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            REARM: begin
               if (rearm_ok && !valid_s) state_q <= IDLE;
            end
            IDLE: begin
               if (push) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end
            end
            ACK: begin
               if (!valid_s) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= REARM;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_byte_receiver.sv
// tb/tb_input_byte_receiver.sv - directed self-checking bench for input_byte_receiver
module tb_input_byte_receiver;

`ifdef INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] data_in;
   logic       input_byte_valid;
   logic       input_acknowledge;
   logic       flush;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;

   int vectors = 0;
   int miscompares = 0;
   bit mon_en = 1'b0;
   logic [7:0] got_q [$];

   input_byte_receiver #(.DEPTH(2)) dut (
      .clk               (clk),
      .nrst              (nrst),
      .data_in           (data_in),
      .input_byte_valid  (input_byte_valid),
      .input_acknowledge (input_acknowledge),
      .flush             (flush),
      .byte_out          (byte_out),
      .byte_valid        (byte_valid),
      .byte_ready        (byte_ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en && byte_valid && byte_ready) got_q.push_back(byte_out);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic lvl, input int budget, output bit ok);
      ok = (input_acknowledge === lvl);
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = (input_acknowledge === lvl);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input int budget, output bit acked);
      bit fell;
      data_in = d;
      input_byte_valid = 1'b1;
      wait_ack(1'b1, budget, acked);
      if (acked) begin
         input_byte_valid = 1'b0;
         wait_ack(1'b0, 10, fell);
         chk("ack_fall", 32'(fell), 32'd1);
      end
   endtask

   task automatic pop_one();
      byte_ready = 1'b1;
      tick();
      byte_ready = 1'b0;
   endtask

   initial begin
      bit ok;
      nrst = 1'b0;
      data_in = 8'h00;
      input_byte_valid = 1'b0;
      flush = 1'b0;
      byte_ready = 1'b0;
      tick();
      tick();
      chk("rst_ack", 32'(input_acknowledge), 32'd0);
      chk("rst_bvalid", 32'(byte_valid), 32'd0);
      nrst = 1'b1;
      repeat (4) tick();

      // single byte: ack rises on the LAT-th edge and falls LAT edges after valid drops
      data_in = 8'hA5;
      input_byte_valid = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         tick();
         chk("single_ack_rise", 32'(input_acknowledge), 32'(i == LAT - 1));
      end
      chk("single_bvalid", 32'(byte_valid), 32'd1);
      chk("single_data", 32'(byte_out), 32'hA5);
      input_byte_valid = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         tick();
         chk("single_ack_fall", 32'(input_acknowledge), 32'(i != LAT - 1));
      end
      pop_one();
      chk("single_empty", 32'(byte_valid), 32'd0);

      // fill and stall
      send_byte(8'h11, 10, ok);
      chk("fill_ack11", 32'(ok), 32'd1);
      send_byte(8'h22, 10, ok);
      chk("fill_ack22", 32'(ok), 32'd1);
      chk("fill_head", 32'(byte_out), 32'h11);
      send_byte(8'h33, 8, ok);
      chk("stall_ack33", 32'(ok), 32'd0);
      pop_one();
      chk("stall_no_push_on_pop", 32'(input_acknowledge), 32'd0);
      chk("stall_head22", 32'(byte_out), 32'h22);
      wait_ack(1'b1, 5, ok);
      chk("stall_ack_late", 32'(ok), 32'd1);
      input_byte_valid = 1'b0;
      wait_ack(1'b0, 10, ok);
      chk("stall_ack_fall", 32'(ok), 32'd1);
      chk("order_22", 32'(byte_out), 32'h22);
      pop_one();
      chk("order_33", 32'(byte_out), 32'h33);
      pop_one();
      chk("order_empty", 32'(byte_valid), 32'd0);

      // simultaneous push and pop with one entry held
      send_byte(8'h44, 10, ok);
      data_in = 8'h55;
      input_byte_valid = 1'b1;
      repeat (LAT - 1) tick();
      byte_ready = 1'b1;
      tick();
      byte_ready = 1'b0;
      chk("pp_ack", 32'(input_acknowledge), 32'd1);
      chk("pp_head", 32'(byte_out), 32'h55);
      chk("pp_bvalid", 32'(byte_valid), 32'd1);
      input_byte_valid = 1'b0;
      wait_ack(1'b0, 10, ok);
      pop_one();
      chk("pp_count1", 32'(byte_valid), 32'd0);

      // reset mid-handshake with valid held high
      data_in = 8'h66;
      input_byte_valid = 1'b1;
      wait_ack(1'b1, 10, ok);
      chk("mid_ack_in", 32'(ok), 32'd1);
      nrst = 1'b0;
      tick();
      chk("mid_rst_ack", 32'(input_acknowledge), 32'd0);
      chk("mid_rst_empty", 32'(byte_valid), 32'd0);
      nrst = 1'b1;
      repeat (8) tick();
      chk("mid_no_capture_ack", 32'(input_acknowledge), 32'd0);
      chk("mid_no_capture_fifo", 32'(byte_valid), 32'd0);
      input_byte_valid = 1'b0;
      repeat (LAT + 3) tick();
      send_byte(8'h77, 10, ok);
      chk("mid_rearm_ack", 32'(ok), 32'd1);
      chk("mid_rearm_data", 32'(byte_out), 32'h77);
      pop_one();

      // flush on the capture edge
      send_byte(8'h88, 10, ok);
      data_in = 8'h99;
      input_byte_valid = 1'b1;
      repeat (LAT - 1) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ack", 32'(input_acknowledge), 32'd1);
      chk("flush_empty", 32'(byte_valid), 32'd0);
      input_byte_valid = 1'b0;
      wait_ack(1'b0, 10, ok);
      chk("flush_ack_fall", 32'(ok), 32'd1);
      chk("flush_still_empty", 32'(byte_valid), 32'd0);

      // wrap-around streaming
      byte_ready = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(i), 10, ok);
         chk("wrap_ack", 32'(ok), 32'd1);
      end
      repeat (3) tick();
      mon_en = 1'b0;
      byte_ready = 1'b0;
      chk("wrap_len", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size()) chk("wrap_data", 32'(got_q[i]), 32'(i));
      end
      chk("wrap_empty", 32'(byte_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/input_byte_receiver.md
INPUT_BYTE_RECEIVER -- requirements
Module: input_byte_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 2: FIFO entries toward the cipher core; power of two, minimum 2.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port nrst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port data_in, input, 8: byte from chip pins; the user holds it stable while input_byte_valid is high.
REQ-005 SHALL have port input_byte_valid, input, 1: user request from chip pin; asynchronous to clk.
REQ-006 SHALL have port input_acknowledge, output, 1: to chip pin; indicates the byte has been captured.
REQ-007 SHALL have port flush, input, 1: from the interface FSM; empties the FIFO.
REQ-008 SHALL have port byte_out, output, 8: FIFO head toward the cipher core.
REQ-009 SHALL have port byte_valid, output, 1: FIFO is non-empty.
REQ-010 SHALL have port byte_ready, input, 1: core consumes the head when byte_valid and byte_ready are both high.

Function
REQ-011 SHALL implement a four-phase handshake: valid high -> capture -> ack high -> valid low -> ack low.
REQ-012 SHALL implement a registered FSM with states REARM, IDLE and ACK.
REQ-013 input_acknowledge SHALL be high exactly while the FSM is in ACK.
REQ-014 SHALL transition REARM -> IDLE on the edge where the sampled valid (valid_s) is 0.
REQ-015 In IDLE, when valid_s is 1 and the FIFO is not full, SHALL push data_in and move to ACK on the same edge.
REQ-016 In IDLE with the FIFO full, SHALL stay in IDLE with ack low; a pop in the same cycle does not enable the push (push evaluated on pre-pop full).
REQ-017 SHALL transition ACK -> IDLE on the edge where valid_s is 0; exactly one push per valid pulse.
REQ-018 byte_out SHALL equal the FIFO head combinationally; byte_out is don't-care when byte_valid is 0.
REQ-019 On byte_valid and byte_ready high, SHALL pop the head at that edge.
REQ-020 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged and preserve order.
REQ-021 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-022 flush high SHALL clear pointers and count at that edge, overriding any same-edge push or pop; the FSM is unaffected.
REQ-023 Pop with an empty FIFO SHALL be ignored.

Reset
REQ-024 On clk edge with nrst low, SHALL set the FSM to REARM, the FIFO to empty, and synchronizer flops to 0.
REQ-025 During and after reset: input_acknowledge=0 and byte_valid=0; byte_out don't-care.
REQ-026 A valid still high across reset SHALL NOT be captured until it first returns low (REARM).

Configuration
REQ-027 With INPUT_SYNC_EN defined: valid_s SHALL be input_byte_valid through a two-flop synchronizer; push occurs 3 edges after valid rises (2 sync + 1 FSM).
REQ-028 Without INPUT_SYNC_EN: valid_s SHALL be input_byte_valid directly; push occurs on the first edge it is seen high.
REQ-029 Handshake order, FIFO behaviour and reset values SHALL be identical in both builds.

Verification
REQ-030 Single byte: reset, data_in=0xA5, valid high (sync build) -> ack high after 3rd edge, byte_valid=1, byte_out=0xA5; drop valid -> ack low 3 edges later.
REQ-031 Fill and stall: DEPTH=2, byte_ready=0, send 0x11, 0x22, then 0x33 -> ack stays low for 0x33; assert byte_ready for one cycle -> 0x11 popped, 0x33 captured next, order 0x22, 0x33.
REQ-032 Simultaneous push and pop: one entry held, byte_ready=1 on the push edge -> count stays 1, head advances correctly.
REQ-033 Reset mid-handshake: nrst low while in ACK with valid high -> ack=0, FIFO empty; valid held high after reset -> no capture until valid low then high again.
REQ-034 Flush coincident with push: flush=1 on the capture edge -> byte_valid=0 next cycle; FSM still enters ACK.
REQ-035 Wrap-around: stream 8 bytes 0x00..0x07 with byte_ready=1 -> output sequence 0x00..0x07 with no loss or duplication.
